vga_timing_gen: RTL and testbench

- Generates the raster scan that drives every sprite/ROM drawer: DrawX/DrawY pixel coordinates, the active-high display-enable `blank`, and active-low hs/vs.
- Also provides a delayed sync/blank copy aligned to drawers that register their colour one or more cycles after DrawX/DrawY.
- Provides frame_start/line_start pulses and a wrapping frame counter for animation stepping.
- Sits between the pixel-clock source and all drawers; its outputs go to the VGA/HDMI output stage.

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, blank/sync decodes, delayed
// sync copies for registered drawers, line/frame pulses and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       pix_blank,
  output logic       pix_hs,
  output logic       pix_vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FW      = 8;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_LO  = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] H_SYNC_HI  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_LO  = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] V_SYNC_HI  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Geometry must fit the 10-bit counters; sync windows use inclusive upper bounds.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (H_SYNC == 0 || V_SYNC == 0 || H_VISIBLE == 0 || V_VISIBLE == 0) begin : g_bad_width
    $error("vga_timing_gen: sync and visible widths must be non-zero");
  end
  if (SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [FW-1:0] frame_cnt;
  logic          hs_win;
  logic          vs_win;
  logic          vis;

  // Raster counters; frame counter steps on the end-of-frame double wrap.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      if (vc == V_LAST) begin
        vc        <= '0;
        frame_cnt <= frame_cnt + FW'(1);
      end else begin
        vc <= vc + CW'(1);
      end
    end else begin
      hc <= hc + CW'(1);
    end
  end

  // Same-cycle decodes, forced idle while reset is asserted.
  always_comb begin
    hs_win = (hc >= H_SYNC_LO) && (hc <= H_SYNC_HI);
    vs_win = (vc >= V_SYNC_LO) && (vc <= V_SYNC_HI);
    vis    = (hc < H_VIS_END) && (vc < V_VIS_END);
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign frame_count = frame_cnt;
  assign blank       = !reset && vis;
  assign hs          = reset || !hs_win;
  assign vs          = reset || !vs_win;
  assign line_start  = !reset && (hc == '0);
  assign frame_start = !reset && (hc == '0) && (vc == '0);

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign pix_blank = blank;
    assign pix_hs    = hs;
    assign pix_vs    = vs;
  end else begin : g_delay
    localparam int unsigned SD = SYNC_DELAY;

    logic [SD-1:0] blank_sr;
    logic [SD-1:0] hs_sr;
    logic [SD-1:0] vs_sr;

    // Shift registers; reset flushes any in-flight history to idle levels.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        blank_sr <= '0;
        hs_sr    <= '1;
        vs_sr    <= '1;
      end else begin
        blank_sr <= (blank_sr << 1) | SD'(blank);
        hs_sr    <= (hs_sr << 1) | SD'(hs);
        vs_sr    <= (vs_sr << 1) | SD'(vs);
      end
    end

    assign pix_blank = blank_sr[SD-1];
    assign pix_hs    = hs_sr[SD-1];
    assign pix_vs    = vs_sr[SD-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 geometry for line-level
// timing, plus a tiny geometry instance for frame-level and wrap behaviour.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  // d_: default geometry, SYNC_DELAY=1
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic d_blank, d_hs, d_vs, d_pblank, d_phs, d_pvs, d_ls, d_fs;
  // z_: default geometry, SYNC_DELAY=0
  logic [9:0] z_x, z_y;
  logic [7:0] z_fc;
  logic z_blank, z_hs, z_vs, z_pblank, z_phs, z_pvs, z_ls, z_fs;
  // t_: default geometry, SYNC_DELAY=3
  logic [9:0] t_x, t_y;
  logic [7:0] t_fc;
  logic t_blank, t_hs, t_vs, t_pblank, t_phs, t_pvs, t_ls, t_fs;
  // s_: 8x7 geometry (4/1/2/1, 3/1/2/1), SYNC_DELAY=2
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;
  logic s_blank, s_hs, s_vs, s_pblank, s_phs, s_pvs, s_ls, s_fs;

  vga_timing_gen #(.SYNC_DELAY(1)) u_d (
    .vga_clk(vga_clk), .reset(reset), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs(d_hs), .vs(d_vs), .pix_blank(d_pblank), .pix_hs(d_phs), .pix_vs(d_pvs),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) u_z (
    .vga_clk(vga_clk), .reset(reset), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
    .hs(z_hs), .vs(z_vs), .pix_blank(z_pblank), .pix_hs(z_phs), .pix_vs(z_pvs),
    .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc));

  vga_timing_gen #(.SYNC_DELAY(3)) u_t (
    .vga_clk(vga_clk), .reset(reset), .DrawX(t_x), .DrawY(t_y), .blank(t_blank),
    .hs(t_hs), .vs(t_vs), .pix_blank(t_pblank), .pix_hs(t_phs), .pix_vs(t_pvs),
    .line_start(t_ls), .frame_start(t_fs), .frame_count(t_fc));

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(2)
  ) u_s (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .pix_blank(s_pblank), .pix_hs(s_phs), .pix_vs(s_pvs),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int hs_low_cnt = 0, hs_first = -1, hs_last = -1;
  int s_vs_low_cnt = 0;
  bit found;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  // Reference raster for the default 800x525 geometry
  function automatic int dm_x(int c); return c % 800; endfunction
  function automatic int dm_y(int c); return (c / 800) % 525; endfunction
  function automatic int dm_blank(int c);
    return (dm_x(c) < 640 && dm_y(c) < 480) ? 1 : 0;
  endfunction
  function automatic int dm_hs(int c);
    return (dm_x(c) >= 656 && dm_x(c) < 752) ? 0 : 1;
  endfunction

  // Reference raster for the 8x7 geometry
  function automatic int sm_x(int c); return c % 8; endfunction
  function automatic int sm_y(int c); return (c / 8) % 7; endfunction
  function automatic int sm_blank(int c);
    return (sm_x(c) < 4 && sm_y(c) < 3) ? 1 : 0;
  endfunction
  function automatic int sm_hs(int c);
    return (sm_x(c) == 5 || sm_x(c) == 6) ? 0 : 1;
  endfunction
  function automatic int sm_vs(int c);
    return (sm_y(c) == 4 || sm_y(c) == 5) ? 0 : 1;
  endfunction

  task automatic check_cycle(input int c);
    chk($sformatf("s_x@%0d", c), s_x, sm_x(c));
    chk($sformatf("s_y@%0d", c), s_y, sm_y(c));
    chk($sformatf("s_blank@%0d", c), s_blank, sm_blank(c));
    chk($sformatf("s_hs@%0d", c), s_hs, sm_hs(c));
    chk($sformatf("s_vs@%0d", c), s_vs, sm_vs(c));
    chk($sformatf("s_ls@%0d", c), s_ls, (sm_x(c) == 0) ? 1 : 0);
    chk($sformatf("s_fs@%0d", c), s_fs, (sm_x(c) == 0 && sm_y(c) == 0) ? 1 : 0);
    chk($sformatf("s_fc@%0d", c), s_fc, (c / 56) % 256);
    chk($sformatf("s_phs@%0d", c), s_phs, (c >= 2) ? sm_hs(c - 2) : 1);
    chk($sformatf("s_pvs@%0d", c), s_pvs, (c >= 2) ? sm_vs(c - 2) : 1);
    chk($sformatf("s_pblank@%0d", c), s_pblank, (c >= 2) ? sm_blank(c - 2) : 0);
    if (c <= 800) begin
      chk($sformatf("d_x@%0d", c), d_x, dm_x(c));
      chk($sformatf("d_y@%0d", c), d_y, dm_y(c));
      chk($sformatf("d_blank@%0d", c), d_blank, dm_blank(c));
      chk($sformatf("d_hs@%0d", c), d_hs, dm_hs(c));
      chk($sformatf("d_vs@%0d", c), d_vs, 1);
      chk($sformatf("d_ls@%0d", c), d_ls, (dm_x(c) == 0) ? 1 : 0);
      chk($sformatf("d_fs@%0d", c), d_fs, (c == 0) ? 1 : 0);
      chk($sformatf("d_pblank@%0d", c), d_pblank, (c >= 1) ? dm_blank(c - 1) : 0);
      chk($sformatf("z_phs@%0d", c), z_phs, dm_hs(c));
      chk($sformatf("z_pblank@%0d", c), z_pblank, dm_blank(c));
      chk($sformatf("t_phs@%0d", c), t_phs, (c >= 3) ? dm_hs(c - 3) : 1);
      chk($sformatf("t_pblank@%0d", c), t_pblank, (c >= 3) ? dm_blank(c - 3) : 0);
    end
  endtask

  initial begin
    // Reset held for three clocks
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_blank", d_blank, 0);
    chk("rst_hs", d_hs, 1);
    chk("rst_vs", d_vs, 1);
    chk("rst_ls", d_ls, 0);
    chk("rst_fs", d_fs, 0);
    chk("rst_pblank", d_pblank, 0);
    chk("rst_phs", d_phs, 1);
    chk("rst_fc", s_fc, 0);

    reset = 1'b0;
    #1;
    cyc = 0;
    // Run 256 small frames plus a margin; default instance checked over its first line
    while (cyc <= 256 * 56 + 8) begin
      check_cycle(cyc);
      if (cyc < 800 && d_hs == 1'b0) begin
        hs_low_cnt++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
      if (cyc < 56 && s_vs == 1'b0) s_vs_low_cnt++;
      if (cyc == 640) chk("blank_fall_640", d_blank, 0);
      if (cyc == 800) begin
        chk("wrap_x", d_x, 0);
        chk("wrap_y", d_y, 1);
        chk("wrap_ls", d_ls, 1);
      end
      if (cyc == 56) chk("s_fc_first", s_fc, 1);
      if (cyc == 256 * 56 - 1) chk("s_fc_255", s_fc, 255);
      if (cyc == 256 * 56) begin
        chk("s_fc_wrap", s_fc, 0);
        chk("s_fc_wrap_fs", s_fs, 1);
      end
      tick();
    end
    chk("hs_low_clocks", hs_low_cnt, 96);
    chk("hs_first_low", hs_first, 656);
    chk("hs_last_low", hs_last, 751);
    chk("s_vs_low_clocks", s_vs_low_cnt, 16);

    // Reset mid-hsync on the default geometry (DrawX=700)
    found = 1'b0;
    for (int i = 0; i < 900 && !found; i++) begin
      if (d_x == 10'd700) found = 1'b1;
      else tick();
    end
    chk("find_x700", found, 1);
    chk("pre_rst_hs", d_hs, 0);
    reset = 1'b1;
    #1;
    chk("rst_now_hs", d_hs, 1);
    tick();
    chk("mid_rst_x", d_x, 0);
    chk("mid_rst_y", d_y, 0);
    chk("mid_rst_hs", d_hs, 1);
    chk("mid_rst_phs", d_phs, 1);
    chk("mid_rst_t_phs", t_phs, 1);
    chk("mid_rst_ls", d_ls, 0);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("post_rst_t_phs%0d", k), t_phs, 1);
      chk($sformatf("post_rst_d_phs%0d", k), d_phs, 1);
      chk($sformatf("post_rst_z_phs%0d", k), z_phs, 1);
      tick();
    end

    // Reset with hs and vs both low on the small geometry, frame_count non-zero
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (s_x == 10'd5 && s_y == 10'd4 && s_fc != 8'd0) found = 1'b1;
      else tick();
    end
    chk("find_s_sync", found, 1);
    chk("s_pre_hs", s_hs, 0);
    chk("s_pre_vs", s_vs, 0);
    chk("s_pre_fc", s_fc, 1);
    reset = 1'b1;
    tick();
    chk("s_rst_x", s_x, 0);
    chk("s_rst_y", s_y, 0);
    chk("s_rst_fc", s_fc, 0);
    chk("s_rst_hs", s_hs, 1);
    chk("s_rst_vs", s_vs, 1);
    chk("s_rst_phs", s_phs, 1);
    chk("s_rst_pvs", s_pvs, 1);
    chk("s_rst_pblank", s_pblank, 0);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s_post_phs%0d", k), s_phs, 1);
      chk($sformatf("s_post_pvs%0d", k), s_pvs, 1);
      chk($sformatf("s_post_pblank%0d", k), s_pblank, (k >= 2) ? sm_blank(k - 2) : 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
